// File: rtl/gmii_rx_frame_if.sv
// Bus bundle between the GMII PHY side and the frame-level receive outputs.
// The framer uses the slave view; the PHY/driver uses the master view.
interface gmii_rx_frame_if;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  data;
    logic        h_data;
    logic        crc_strobe;
    logic        crc_ok;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    modport master (
        output gmii_rxd, gmii_rx_dv, gmii_rx_er,
        input  data, h_data, crc_strobe, crc_ok, good_cnt, bad_cnt
    );

    modport slave (
        input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
        output data, h_data, crc_strobe, crc_ok, good_cnt, bad_cnt
    );
endinterface

// File: rtl/gmii_rx_frame.sv
// GMII receive framer: strips preamble/SFD, emits frame octets, checks CRC-32
// and length, and reports an end-of-frame verdict with good/bad counters.
//
// state | meaning
// IDLE  | waiting for carrier; first octet must be 0x55
// PRE   | counting 0x55 preamble octets, waiting for SFD 0xD5
// FRAME | emitting frame octets, running CRC and length
// DROP  | malformed preamble; discard until carrier drops
module gmii_rx_frame #(
    parameter int jumbo_dw = 14,
    parameter int min_pre  = 2,
    parameter int min_len  = 64
) (
    input  logic            clk,
    input  logic            rst,
    gmii_rx_frame_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, PRE, FRAME, DROP} state_t;

    localparam logic [31:0]         crc_residue = 32'hDEBB20E3;
    localparam logic [jumbo_dw-1:0] len_max     = '1;
    localparam logic [jumbo_dw-1:0] min_len_w   = jumbo_dw'(min_len);

    state_t              state, state_nxt;
    logic [7:0]          rxd_q;
    logic                dv_q, er_q;
    logic [2:0]          pre_cnt, pre_cnt_nxt;
    logic [31:0]         crc, crc_nxt;
    logic [jumbo_dw-1:0] len, len_nxt;
    logic                err, err_nxt;
    logic                ovf, ovf_nxt;
    logic [7:0]          data_nxt;
    logic                h_data_nxt, strobe_nxt, ok_nxt, drop_done;
    logic [1:0]          bad_inc;

    // Reflected CRC-32, one octet per clock, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i])
                r = (r >> 1) ^ 32'hEDB88320;
            else
                r = r >> 1;
        end
        return r;
    endfunction

    always_comb begin
        state_nxt   = state;
        pre_cnt_nxt = pre_cnt;
        crc_nxt     = crc;
        len_nxt     = len;
        err_nxt     = err;
        ovf_nxt     = ovf;
        data_nxt    = 8'd0;
        h_data_nxt  = 1'b0;
        strobe_nxt  = 1'b0;
        ok_nxt      = 1'b0;
        drop_done   = 1'b0;

        case (state)
            IDLE: begin
                if (dv_q) begin
                    if (rxd_q == 8'h55) begin
                        state_nxt   = PRE;
                        pre_cnt_nxt = 3'd1;
                    end else begin
                        state_nxt = DROP;
                    end
                end
            end
            PRE: begin
                if (!dv_q) begin
                    state_nxt = IDLE;
                end else if (rxd_q == 8'h55) begin
                    if (pre_cnt != 3'd7)
                        pre_cnt_nxt = pre_cnt + 3'd1;
                end else if (rxd_q == 8'hD5 && int'(pre_cnt) >= min_pre) begin
                    state_nxt = FRAME;
                    crc_nxt   = 32'hFFFFFFFF;
                    len_nxt   = '0;
                    err_nxt   = 1'b0;
                    ovf_nxt   = 1'b0;
                end else begin
                    state_nxt = DROP;
                end
            end
            FRAME: begin
                if (dv_q) begin
                    data_nxt   = rxd_q;
                    h_data_nxt = 1'b1;
                    crc_nxt    = crc32_byte(crc, rxd_q);
                    if (len == len_max)
                        ovf_nxt = 1'b1;
                    else
                        len_nxt = len + jumbo_dw'(1);
                    if (er_q)
                        err_nxt = 1'b1;
                end else begin
                    // crc/len already include the last octet, so the verdict is ready now
                    state_nxt  = IDLE;
                    strobe_nxt = 1'b1;
                    ok_nxt     = (crc == crc_residue) && (len >= min_len_w) && !err && !ovf;
                end
            end
            DROP: begin
                if (!dv_q) begin
                    state_nxt = IDLE;
                    drop_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bad_inc = {1'b0, bus.crc_strobe & ~bus.crc_ok} + {1'b0, drop_done};

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_q          <= 8'd0;
            dv_q           <= 1'b0;
            er_q           <= 1'b0;
            state          <= IDLE;
            pre_cnt        <= 3'd0;
            crc            <= 32'hFFFFFFFF;
            len            <= '0;
            err            <= 1'b0;
            ovf            <= 1'b0;
            bus.data       <= 8'd0;
            bus.h_data     <= 1'b0;
            bus.crc_strobe <= 1'b0;
            bus.crc_ok     <= 1'b0;
            bus.good_cnt   <= 16'd0;
            bus.bad_cnt    <= 16'd0;
        end else begin
            rxd_q          <= bus.gmii_rxd;
            dv_q           <= bus.gmii_rx_dv;
            er_q           <= bus.gmii_rx_er;
            state          <= state_nxt;
            pre_cnt        <= pre_cnt_nxt;
            crc            <= crc_nxt;
            len            <= len_nxt;
            err            <= err_nxt;
            ovf            <= ovf_nxt;
            bus.data       <= data_nxt;
            bus.h_data     <= h_data_nxt;
            bus.crc_strobe <= strobe_nxt;
            bus.crc_ok     <= ok_nxt;
            if (bus.crc_strobe && bus.crc_ok)
                bus.good_cnt <= bus.good_cnt + 16'd1;
            bus.bad_cnt    <= bus.bad_cnt + {14'd0, bad_inc};
        end
    end

endmodule

// File: tb/tb_gmii_rx_frame.sv
// Randomized bench for gmii_rx_frame against a table-driven CRC/verdict model.
module tb_gmii_rx_frame;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gmii_rx_frame_if bus();

    gmii_rx_frame #(.jumbo_dw(14), .min_pre(2), .min_len(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] crc_tbl [256];
    logic [7:0]  frm [$];
    logic [7:0]  exp_q [$];
    int          exp_good = 0;
    int          exp_bad  = 0;
    int          tx_first = 0;

    // monitor state
    logic [7:0] rx_q [$];
    int first_h = -1, last_h = -1, strobe_cnt = 0, ok_cnt = 0, strobe_cyc = -1, h_runs = 0, stray = 0;
    logic h_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.h_data) begin
            rx_q.push_back(bus.data);
            if (first_h < 0) first_h = cyc;
            last_h = cyc;
            if (!h_prev) h_runs++;
        end
        if (bus.crc_strobe) begin
            strobe_cnt++;
            if (bus.crc_ok) ok_cnt++;
            strobe_cyc = cyc;
        end else if (bus.crc_ok) begin
            stray++;
        end
        h_prev = bus.h_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        rx_q.delete();
        first_h = -1; last_h = -1; strobe_cnt = 0; ok_cnt = 0;
        strobe_cyc = -1; h_runs = 0;
    endtask

    function automatic logic [31:0] crc_over(input logic [7:0] q[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (q[i]) c = (c >> 8) ^ crc_tbl[(c ^ {24'd0, q[i]}) & 32'hFF];
        return c;
    endfunction

    task automatic build_frame(input int npay, input int flip_idx, input bit no55);
        logic [7:0]  b;
        logic [31:0] fcs;
        frm.delete();
        for (int i = 0; i < npay; i++) begin
            b = 8'($urandom);
            if (no55 && b == 8'h55) b = 8'h56;
            frm.push_back(b);
        end
        fcs = ~crc_over(frm);
        for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
        if (flip_idx >= 0) frm[flip_idx] = frm[flip_idx] ^ 8'h01;
    endtask

    task automatic send_oct(input logic [7:0] b, input logic er);
        @(posedge clk); #1;
        bus.gmii_rxd   = b;
        bus.gmii_rx_dv = 1'b1;
        bus.gmii_rx_er = er;
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        bus.gmii_rx_dv = 1'b0;
        bus.gmii_rx_er = 1'b0;
        bus.gmii_rxd   = 8'h00;
        for (int i = 1; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int npre, input int er_idx, input int gap);
        for (int i = 0; i < npre; i++) send_oct(8'h55, 1'b0);
        send_oct(8'hD5, 1'b0);
        foreach (frm[i]) begin
            send_oct(frm[i], i == er_idx);
            if (i == 0) tx_first = cyc;
        end
        idle(gap);
    endtask

    // verdict from the frame-level rules: residue, minimum length, no rx_er
    task automatic check_frame(input string tag, input bit er_present);
        bit ok;
        int mism = 0;
        ok = (crc_over(frm) == 32'hDEBB20E3) && (frm.size() >= 64) && !er_present;
        if (ok) exp_good++; else exp_bad++;
        check({tag, "_len"}, rx_q.size(), frm.size());
        foreach (frm[i]) if (i < rx_q.size() && rx_q[i] !== frm[i]) mism++;
        check({tag, "_data"}, mism, 0);
        check({tag, "_latency"}, first_h - tx_first, 2);
        check({tag, "_strobes"}, strobe_cnt, 1);
        check({tag, "_strobe_pos"}, strobe_cyc, last_h + 1);
        check({tag, "_crc_ok"}, ok_cnt, ok);
        check({tag, "_good_cnt"}, bus.good_cnt, exp_good);
        check({tag, "_bad_cnt"}, bus.bad_cnt, exp_bad);
    endtask

    initial begin
        logic [31:0] c;
        int mism;
        for (int n = 0; n < 256; n++) begin
            c = n;
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tbl[n] = c;
        end

        rst = 1'b1;
        bus.gmii_rxd = 8'h00; bus.gmii_rx_dv = 1'b0; bus.gmii_rx_er = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_data", bus.data, 0);
        check("rst_h_data", bus.h_data, 0);
        check("rst_strobe", bus.crc_strobe, 0);
        check("rst_good", bus.good_cnt, 0);
        check("rst_bad", bus.bad_cnt, 0);
        idle(2);

        clear_mon(); build_frame(60, -1, 0); drive(7, -1, 6); check_frame("good64", 0);
        clear_mon(); build_frame(60, 20, 0); drive(7, -1, 6); check_frame("flip20", 0);
        clear_mon(); build_frame(36, -1, 0); drive(7, -1, 6); check_frame("runt40", 0);
        clear_mon(); build_frame(60, -1, 0); drive(7, 30, 6); check_frame("rxer30", 1);

        for (int r = 0; r < 6; r++) begin
            int flip;
            clear_mon();
            build_frame($urandom_range(40, 120), -1, 0);
            flip = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, frm.size() - 1)) : -1;
            if (flip >= 0) frm[flip] = frm[flip] ^ 8'h80;
            drive($urandom_range(2, 7), -1, $urandom_range(3, 8));
            check_frame("rand", 0);
        end

        // bad SFD-position octet 0x5D
        clear_mon();
        send_oct(8'h55, 1'b0); send_oct(8'h55, 1'b0); send_oct(8'h5D, 1'b0);
        for (int i = 0; i < 10; i++) send_oct(8'($urandom), 1'b0);
        idle(6);
        exp_bad++;
        check("drop5d_h", rx_q.size(), 0);
        check("drop5d_strobe", strobe_cnt, 0);
        check("drop5d_bad", bus.bad_cnt, exp_bad);

        // preamble too short
        clear_mon(); build_frame(60, -1, 0); drive(1, -1, 6);
        exp_bad++;
        check("shortpre_h", rx_q.size(), 0);
        check("shortpre_strobe", strobe_cnt, 0);
        check("shortpre_bad", bus.bad_cnt, exp_bad);
        check("shortpre_good", bus.good_cnt, exp_good);

        // back-to-back with a single dv=0 gap
        clear_mon();
        exp_q.delete();
        build_frame(60, -1, 0); exp_q = frm; drive(7, -1, 1);
        build_frame(60, -1, 0); foreach (frm[i]) exp_q.push_back(frm[i]); drive(7, -1, 6);
        exp_good += 2;
        check("b2b_runs", h_runs, 2);
        check("b2b_len", rx_q.size(), 128);
        mism = 0;
        foreach (exp_q[i]) if (i < rx_q.size() && rx_q[i] !== exp_q[i]) mism++;
        check("b2b_data", mism, 0);
        check("b2b_strobes", strobe_cnt, 2);
        check("b2b_ok", ok_cnt, 2);
        check("b2b_good", bus.good_cnt, exp_good);

        // reset mid-frame with dv kept high
        clear_mon();
        build_frame(60, -1, 1);
        for (int i = 0; i < 7; i++) send_oct(8'h55, 1'b0);
        send_oct(8'hD5, 1'b0);
        foreach (frm[i]) begin
            send_oct(frm[i], 1'b0);
            rst = (i == 30);
            if (i == 31) begin
                check("mid_rst_h", bus.h_data, 0);
                check("mid_rst_data", bus.data, 0);
                check("mid_rst_good", bus.good_cnt, 0);
                check("mid_rst_bad", bus.bad_cnt, 0);
                clear_mon();
            end
        end
        idle(6);
        exp_good = 0; exp_bad = 1;
        check("mid_rst_strobe", strobe_cnt, 0);
        check("mid_rst_h_after", rx_q.size(), 0);
        check("mid_rst_bad_after", bus.bad_cnt, exp_bad);
        clear_mon(); build_frame(60, -1, 0); drive(7, -1, 6); check_frame("post_rst", 0);

        check("stray_crc_ok", stray, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
